// File: rtl/synth_kbd_pkg.sv
// Shared scan-code, key-index and FSM definitions
// for the PS/2 synth keyboard event controller.
package synth_kbd_pkg;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;

   localparam logic [7:0] SC_C      = 8'h1C;
   localparam logic [7:0] SC_CS     = 8'h1D;
   localparam logic [7:0] SC_D      = 8'h1B;
   localparam logic [7:0] SC_DS     = 8'h24;
   localparam logic [7:0] SC_E      = 8'h23;
   localparam logic [7:0] SC_F      = 8'h2B;
   localparam logic [7:0] SC_FS     = 8'h2C;
   localparam logic [7:0] SC_G      = 8'h34;
   localparam logic [7:0] SC_GS     = 8'h35;
   localparam logic [7:0] SC_A      = 8'h33;
   localparam logic [7:0] SC_AS     = 8'h3C;
   localparam logic [7:0] SC_B      = 8'h3B;
   localparam logic [7:0] SC_OCT_DN = 8'h1A;
   localparam logic [7:0] SC_OCT_UP = 8'h22;
   localparam logic [7:0] SC_AMP_DN = 8'h16;
   localparam logic [7:0] SC_AMP_UP = 8'h1E;

   localparam logic [3:0] KEY_OCT_DN = 4'd12;
   localparam logic [3:0] KEY_OCT_UP = 4'd13;
   localparam logic [3:0] KEY_AMP_DN = 4'd14;
   localparam logic [3:0] KEY_AMP_UP = 4'd15;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BRK,
      S_EXT,
      S_EXT_BRK
   } kbd_state_t;

   function automatic logic [3:0] lowest_note(input logic [11:0] m);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 11; i >= 0; i--) begin
         if (m[i]) r = 4'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/kbd_code_lut.sv
// Combinational scan-code to key-index map.
module kbd_code_lut
   import synth_kbd_pkg::*;
(
   input  logic [7:0] byte_data,
   output logic [3:0] idx,
   output logic       hit
);

   always_comb begin
      idx = 4'd0;
      hit = 1'b1;
      case (byte_data)
         SC_C:      idx = 4'd0;
         SC_CS:     idx = 4'd1;
         SC_D:      idx = 4'd2;
         SC_DS:     idx = 4'd3;
         SC_E:      idx = 4'd4;
         SC_F:      idx = 4'd5;
         SC_FS:     idx = 4'd6;
         SC_G:      idx = 4'd7;
         SC_GS:     idx = 4'd8;
         SC_A:      idx = 4'd9;
         SC_AS:     idx = 4'd10;
         SC_B:      idx = 4'd11;
         SC_OCT_DN: idx = KEY_OCT_DN;
         SC_OCT_UP: idx = KEY_OCT_UP;
         SC_AMP_DN: idx = KEY_AMP_DN;
         SC_AMP_UP: idx = KEY_AMP_UP;
         default:   hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/kbd_event_ctrl.sv
// PS/2 byte stream to synth note/gate, octave and amplitude state,
// with typematic suppression and prefix timeout.
module kbd_event_ctrl
   import synth_kbd_pkg::*;
#(
   parameter int OCT_DEFAULT    = 4,
   parameter int OCT_MAX        = 7,
   parameter int AMP_DEFAULT    = 8,
   parameter int AMP_MAX        = 15,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic [3:0]  note,
   output logic        gate,
   output logic        note_on_pulse,
   output logic [2:0]  octave,
   output logic [3:0]  amp,
   output logic [15:0] key_held
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYCLES - 1);

   kbd_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    note_d, amp_d, idx;
   logic [2:0]    oct_d;
   logic [15:0]   held_d;
   logic          gate_d, pulse_d, hit, make, brk;

   kbd_code_lut u_lut (
      .byte_data (byte_data),
      .idx       (idx),
      .hit       (hit)
   );

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         note          <= 4'd0;
         gate          <= 1'b0;
         note_on_pulse <= 1'b0;
         octave        <= 3'(OCT_DEFAULT);
         amp           <= 4'(AMP_DEFAULT);
         key_held      <= 16'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         note          <= note_d;
         gate          <= gate_d;
         note_on_pulse <= pulse_d;
         octave        <= oct_d;
         amp           <= amp_d;
         key_held      <= held_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      make    = 1'b0;
      brk     = 1'b0;
      if (byte_valid) begin
         // a byte arriving on the expiry cycle is still decoded in-state
         unique case (state_q)
            S_IDLE: begin
               if (byte_data == SC_BREAK)    state_d = S_BRK;
               else if (byte_data == SC_EXT) state_d = S_EXT;
               else                          make    = hit;
            end
            S_BRK: begin
               brk     = hit;
               state_d = S_IDLE;
            end
            S_EXT: begin
               state_d = (byte_data == SC_BREAK) ? S_EXT_BRK : S_IDLE;
            end
            S_EXT_BRK: state_d = S_IDLE;
         endcase
      end else if (state_q != S_IDLE) begin
         if (cnt_q == CNT_LIM) state_d = S_IDLE;
         else                  cnt_d   = cnt_q + 1'b1;
      end
   end

   always_comb begin
      held_d  = key_held;
      note_d  = note;
      gate_d  = gate;
      pulse_d = 1'b0;
      oct_d   = octave;
      amp_d   = amp;
      if (make && !key_held[idx]) begin
         held_d[idx] = 1'b1;
         unique case (1'b1)
            (idx < 4'd12): begin
               note_d  = idx;
               gate_d  = 1'b1;
               pulse_d = 1'b1;
            end
            (idx == KEY_OCT_DN):
               if (octave != 3'd0) oct_d = octave - 3'd1;
            (idx == KEY_OCT_UP):
               if (octave != 3'(OCT_MAX)) oct_d = octave + 3'd1;
            (idx == KEY_AMP_DN):
               if (amp != 4'd0) amp_d = amp - 4'd1;
            (idx == KEY_AMP_UP):
               if (amp != 4'(AMP_MAX)) amp_d = amp + 4'd1;
         endcase
      end
      if (brk) begin
         held_d[idx] = 1'b0;
         if (idx < 4'd12 && key_held[idx] && idx == note) begin
            // legato: fall back to the lowest note still held
            if (|held_d[11:0]) note_d = lowest_note(held_d[11:0]);
            else               gate_d = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Directed self-checking bench for kbd_event_ctrl.
module tb_kbd_event_ctrl;

   localparam int TO = 40;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic [3:0]  note;
   logic        gate;
   logic        note_on_pulse;
   logic [2:0]  octave;
   logic [3:0]  amp;
   logic [15:0] key_held;

   int tests = 0;
   int failed = 0;

   kbd_event_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .CLOCK_50      (clk),
      .resetn        (rst_n),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .note          (note),
      .gate          (gate),
      .note_on_pulse (note_on_pulse),
      .octave        (octave),
      .amp           (amp),
      .key_held      (key_held)
   );

   always #10 clk = ~clk;

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      byte_valid = 1'b0;
      idle(2);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle(2);
      tests++;
      if ({note, gate, note_on_pulse, octave, amp, key_held}
          !== {4'd0, 1'b0, 1'b0, 3'd4, 4'd8, 16'h0}) begin
         failed++;
         $display("FAIL reset: note=%0d gate=%0b pulse=%0b oct=%0d amp=%0d held=%h, want 0 0 0 4 8 0000",
                  note, gate, note_on_pulse, octave, amp, key_held);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
   endtask

   task automatic test_make();
      do_reset();
      send(8'h1C);
      tests++;
      if ({note, gate, note_on_pulse, key_held} !== {4'd0, 1'b1, 1'b1, 16'h0001}) begin
         failed++;
         $display("FAIL make: note=%0d gate=%0b pulse=%0b held=%h, want 0 1 1 0001",
                  note, gate, note_on_pulse, key_held);
      end
      idle(1);
      tests++;
      if (note_on_pulse !== 1'b0) begin
         failed++;
         $display("FAIL make_pulse_width: pulse=%0b, want 0", note_on_pulse);
      end
   endtask

   task automatic test_typematic();
      int pulses;
      do_reset();
      pulses = 0;
      repeat (3) begin
         send(8'h1C);
         if (note_on_pulse === 1'b1) pulses++;
      end
      send(8'hF0);
      if (note_on_pulse === 1'b1) pulses++;
      send(8'h1C);
      if (note_on_pulse === 1'b1) pulses++;
      tests++;
      if (pulses != 1) begin
         failed++;
         $display("FAIL typematic_pulses: got %0d, want 1", pulses);
      end
      tests++;
      if ({note, gate, key_held} !== {4'd0, 1'b0, 16'h0}) begin
         failed++;
         $display("FAIL typematic_break: note=%0d gate=%0b held=%h, want 0 0 0000",
                  note, gate, key_held);
      end
   endtask

   task automatic test_legato();
      do_reset();
      send(8'h23);
      send(8'h33);
      tests++;
      if ({note, gate, note_on_pulse, key_held} !== {4'd9, 1'b1, 1'b1, 16'h0210}) begin
         failed++;
         $display("FAIL legato_make: note=%0d gate=%0b pulse=%0b held=%h, want 9 1 1 0210",
                  note, gate, note_on_pulse, key_held);
      end
      send(8'hF0);
      send(8'h33);
      tests++;
      if ({note, gate, note_on_pulse, key_held} !== {4'd4, 1'b1, 1'b0, 16'h0010}) begin
         failed++;
         $display("FAIL legato_break: note=%0d gate=%0b pulse=%0b held=%h, want 4 1 0 0010",
                  note, gate, note_on_pulse, key_held);
      end
   endtask

   task automatic press_release(input logic [7:0] sc);
      send(sc);
      send(8'hF0);
      send(sc);
   endtask

   task automatic test_octave_amp();
      logic [2:0] oup [9] = '{3'd5, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
      logic [2:0] odn [9] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
      logic [3:0] adn [9] = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
      int bad;
      do_reset();
      bad = 0;
      for (int i = 0; i < 9; i++) begin
         press_release(8'h22);
         if (octave !== oup[i]) bad++;
      end
      tests++;
      if (bad != 0 || octave !== 3'd7) begin
         failed++;
         $display("FAIL octave_up_sat: oct=%0d errors=%0d, want 7", octave, bad);
      end
      bad = 0;
      for (int i = 0; i < 9; i++) begin
         press_release(8'h1A);
         if (octave !== odn[i]) bad++;
      end
      tests++;
      if (bad != 0 || octave !== 3'd0) begin
         failed++;
         $display("FAIL octave_dn_sat: oct=%0d errors=%0d, want 0", octave, bad);
      end
      bad = 0;
      for (int i = 0; i < 9; i++) begin
         press_release(8'h16);
         if (amp !== adn[i]) bad++;
      end
      tests++;
      if (bad != 0 || amp !== 4'd0) begin
         failed++;
         $display("FAIL amp_dn_sat: amp=%0d errors=%0d, want 0", amp, bad);
      end
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         press_release(8'h1E);
         if (amp !== ((i < 15) ? 4'(i + 1) : 4'd15)) bad++;
      end
      tests++;
      if (bad != 0 || amp !== 4'd15 || key_held !== 16'h0) begin
         failed++;
         $display("FAIL amp_up_sat: amp=%0d errors=%0d held=%h, want 15 0000",
                  amp, bad, key_held);
      end
   endtask

   task automatic test_extended();
      do_reset();
      send(8'hE0);
      send(8'h1C);
      send(8'hE0);
      send(8'hF0);
      send(8'h1C);
      send(8'hAA);
      send(8'h55);
      tests++;
      if ({note, gate, note_on_pulse, octave, amp, key_held}
          !== {4'd0, 1'b0, 1'b0, 3'd4, 4'd8, 16'h0}) begin
         failed++;
         $display("FAIL extended_ignored: note=%0d gate=%0b held=%h oct=%0d amp=%0d",
                  note, gate, key_held, octave, amp);
      end
      send(8'h1C);
      tests++;
      if ({gate, note_on_pulse, key_held} !== {1'b1, 1'b1, 16'h0001}) begin
         failed++;
         $display("FAIL extended_back_idle: gate=%0b pulse=%0b held=%h, want 1 1 0001",
                  gate, note_on_pulse, key_held);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      send(8'h1C);
      send(8'hF0);
      idle(TO / 2);
      send(8'h1C);
      tests++;
      if ({gate, key_held} !== {1'b0, 16'h0}) begin
         failed++;
         $display("FAIL prefix_held: gate=%0b held=%h, want 0 0000", gate, key_held);
      end
      send(8'hF0);
      idle(TO + 2);
      send(8'h1C);
      tests++;
      if ({note, gate, note_on_pulse, key_held} !== {4'd0, 1'b1, 1'b1, 16'h0001}) begin
         failed++;
         $display("FAIL prefix_timeout: note=%0d gate=%0b pulse=%0b held=%h, want 0 1 1 0001",
                  note, gate, note_on_pulse, key_held);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      send(8'h22);
      send(8'h1E);
      send(8'h3B);
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({note, gate, note_on_pulse, octave, amp, key_held}
          !== {4'd0, 1'b0, 1'b0, 3'd4, 4'd8, 16'h0}) begin
         failed++;
         $display("FAIL async_reset: note=%0d gate=%0b oct=%0d amp=%0d held=%h, want 0 0 4 8 0000",
                  note, gate, octave, amp, key_held);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
   endtask

   initial begin
      test_reset();
      test_make();
      test_typematic();
      test_legato();
      test_octave_amp();
      test_extended();
      test_timeout();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/kbd_event_ctrl.md
Name: kbd_event_ctrl

Overview:
Sequences the raw PS/2 byte stream into synth control events for the synthesiser's voice datapath.
- Decodes make, break (F0) and extended (E0) prefixes.
- Tracks which of 16 control keys are held and suppresses typematic repeats.
- Owns the note/gate, octave and amplitude registers, so downstream tone and ADSR blocks see clean, saturated state instead of raw scan codes.

Parameters:
- OCT_DEFAULT, 4, octave value after reset (0..OCT_MAX).
- OCT_MAX, 7, upper saturation limit of octave.
- AMP_DEFAULT, 8, amplitude value after reset (0..AMP_MAX).
- AMP_MAX, 15, upper saturation limit of amp.
- TIMEOUT_CYCLES, 1000000, cycles an open prefix (F0/E0) is held before it is abandoned (20 ms at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous, active-low reset.
- byte_valid  in  1  one-cycle strobe: byte_data holds a new received PS/2 byte (already synchronised to CLOCK_50).
- byte_data  in  8  received scan-code byte.
- note  out  4  current note index: 0=C .. 11=B.
- gate  out  1  high while at least one note key is held.
- note_on_pulse  out  1  one-cycle pulse on each new note attack.
- octave  out  3  current octave, 0..OCT_MAX.
- amp  out  4  current amplitude, 0..AMP_MAX.
- key_held  out  16  held mask: bits 0-11 notes, 12=oct-, 13=oct+, 14=amp-, 15=amp+.

Behaviour:
Reset (async, resetn=0):
- State S_IDLE; timeout counter 0.
- note=0, gate=0, note_on_pulse=0, octave=OCT_DEFAULT, amp=AMP_DEFAULT, key_held=0.

Key map (scan code -> index):
- Notes: 1C=0, 1D=1, 1B=2, 24=3, 23=4, 2B=5, 2C=6, 34=7, 35=8, 33=9, 3C=10, 3B=11.
- Controls: 1A=12, 22=13, 16=14, 1E=15.
- All other codes are unmapped.

Timing:
- All outputs are registered and update on the CLOCK_50 edge after the byte_valid cycle (latency 1).
- note_on_pulse is high for exactly that one cycle.

FSM states and transitions (taken only on byte_valid):
- S_IDLE: F0 -> S_BRK; E0 -> S_EXT; mapped code -> make event, stay in S_IDLE; any other code (AA, FA, FE, unmapped) is ignored.
- S_BRK: mapped code -> break event, then S_IDLE; any other byte -> S_IDLE, no effect.
- S_EXT: F0 -> S_EXT_BRK; any other byte -> S_IDLE, extended key discarded.
- S_EXT_BRK: any byte -> S_IDLE, discarded.

Prefix timeout:
- Counter clears on every byte_valid and increments while in any state other than S_IDLE.
- On reaching TIMEOUT_CYCLES-1 the FSM returns to S_IDLE.
- If byte_valid arrives in the same cycle the counter expires, the byte is processed in the current state; the byte wins.

Make event, key index k:
- If key_held[k] is already 1, the make is a typematic repeat: no change.
- Otherwise set key_held[k], then:
  - k<12: note=k, gate=1, note_on_pulse=1.
  - k=12: octave -= 1, saturating at 0.
  - k=13: octave += 1, saturating at OCT_MAX.
  - k=14: amp -= 1, saturating at 0.
  - k=15: amp += 1, saturating at AMP_MAX.

Break event, key index k:
- Clear key_held[k].
- If k<12 and k==note: if other note bits are still held, note = lowest held index, gate stays 1, no pulse (legato); otherwise gate=0 and note keeps its value.
- Breaking a key that is not held only clears the (already-clear) bit; no other effect.

Arithmetic: octave and amp are unsigned; saturation is checked before the update, so values never wrap.

Decomposition:
- Shared package synth_kbd_pkg holds: scan-code constants (SC_BREAK=F0, SC_EXT=E0, and the 16 key codes), key index constants (KEY_OCT_DN=12 .. KEY_AMP_UP=15), and the FSM state typedef.
- One sub-module: kbd_code_lut, purely combinational. Maps byte_data to a 4-bit index plus a hit flag.

Test Plan:
1. Reset, then byte 1C -> one cycle later note=0, gate=1, note_on_pulse=1 for one cycle, key_held=0x0001.
2. 1C, 1C, 1C (typematic), then F0 1C -> exactly one note_on_pulse; after the break gate=0, note=0, key_held=0.
3. Make 23, then make 33, then F0 33 -> note=9 with a pulse; after the break note=4, gate=1, no second pulse.
4. 22 pressed and released nine times from reset -> octave steps 5,6,7,7,7,...; then 1A pressed and released nine times -> octave reaches 0 and holds. Repeat the same pattern with 16/1E: amp saturates at 0 and 15.
5. E0 1C, then E0 F0 1C -> no output change, FSM back in S_IDLE, key_held=0.
6. F0, then no byte for TIMEOUT_CYCLES, then 1C -> treated as a make (note=0, gate=1). Also assert resetn low mid-sequence with 1C held -> all outputs return to reset values asynchronously.
